lru_replace_ctrl: RTL
=====================

Name: lru_replace_ctrl

Overview:
Sequencing controller for one 8-way cache set whose recency ranks live in the team's 8-entry LRU rank block (ranks 3'b111 MRU, 3'b000 LRU).
- Owns the per-way tag and valid registers.
- Accepts one lookup at a time and resolves hit or miss.
- Chooses the victim on a miss, runs the refill handshake, then issues exactly one LRU write per request.
- Returns a hit/way response to the requester.

Parameters:
TAG_W, 20, width of stored and requested tags
WAYS, 8, number of ways; fixed at 8, since the LRU rank block is 8x3 bits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-low
req_valid  in  1  lookup request valid
req_ready  out  1  controller can accept a request (high only in IDLE)
req_tag  in  TAG_W  lookup tag
flush  in  1  invalidate all ways; sampled only in IDLE
resp_valid  out  1  response valid; held until resp_ready
resp_ready  in  1  requester accepts response
resp_hit  out  1  1 = hit, 0 = miss that was refilled
resp_way  out  3  way that holds the tag
refill_req_valid  out  1  refill request to next level; held until refill_req_ready
refill_req_ready  in  1  next level accepts refill request
refill_req_tag  out  TAG_W  tag to fetch
refill_req_way  out  3  victim way being filled
refill_done  in  1  single-cycle pulse: refill data written into the way
lru_rank  in  24  ranks from the LRU block; way i is bits [3i+2:3i]
lru_way_onehot  out  8  one-hot way to the LRU block
lru_we  out  1  LRU write enable, single-cycle pulse
lru_hit  out  1  LRU update mode: 1 = promote lru_way_onehot to MRU, 0 = rotate (rank-0 way becomes MRU)

Behaviour:
- States: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, UPDATE, RESP.
- Reset (rst=0 at a clk edge) from any state:
  - state goes to IDLE and all valid bits clear; tags are don't-care.
  - all outputs are 0 except req_ready=1.
  - an outstanding refill is abandoned; no lru_we is issued.
- IDLE:
  - req_ready=1.
  - flush=1: clear all valid bits and ignore req_valid this cycle (flush wins).
  - else req_valid=1: latch req_tag, go to LOOKUP.
- LOOKUP (1 cycle): compare the latched tag against the 8 valid tags.
  - Hit: record hit way W (lowest index if duplicates exist), set hit flag, go to UPDATE.
  - Miss, victim selection:
    - lowest-index invalid way; else the way with lru_rank==3'b000.
    - if no rank equals 0 (corrupt ranks), use way 0.
    - latch the victim, go to REFILL_REQ.
- REFILL_REQ:
  - refill_req_valid=1, tag and way stable.
  - on refill_req_ready=1, go to REFILL_WAIT.
- REFILL_WAIT:
  - wait for refill_done.
  - refill_done arriving in REFILL_REQ is ignored (protocol error, not latched).
  - when refill_done arrives here: write the tag, set the valid bit, go to UPDATE.
- UPDATE (1 cycle): lru_we=1 and lru_way_onehot=onehot(W).
  - Hit: lru_hit=1.
  - Miss filled into the rank-0 way: lru_hit=0 (rotation makes it MRU).
  - Miss filled into an invalid way: lru_hit=1 (promote that way).
  - Go to RESP.
- RESP:
  - resp_valid=1, resp_hit and resp_way stable.
  - on resp_ready=1, go to IDLE.
- Latency:
  - hit: request accepted at edge 0, lru_we high during cycle 2, resp_valid high from cycle 3.
  - miss adds the refill handshake time.
- Ordering: lru_we fires exactly once per completed request and never outside UPDATE. lru_way_onehot is all-zero outside UPDATE.
- Outputs are registered or decoded from state only; no combinational path from req_valid to any output except none (req_ready is state-decoded).

Decomposition:
- Package lru_ctrl_pkg holds:
  - the state enum;
  - constants WAYS=8, RANK_W=3, RANK_LRU=3'b000, RANK_MRU=3'b111;
  - an onehot-to-index helper function.
- One sub-module is natural: lru_victim_sel. It is combinational: valid[7:0] plus lru_rank go in; victim index and a victim_invalid flag come out.

Test Plan:
- Reset, then req tag 0x00AB1 -> miss; refill_req_way=0 (lowest invalid); after refill_done, lru_we with lru_hit=1 and onehot 8'h01; resp_hit=0, resp_way=0.
- Fill all 8 ways with tags 1..8 (ranks 0..7 driven from the bench model), then req tag 9 -> victim is the way with rank 0; lru_hit=0; resp_way equals that way.
- Ways full, req tag 5 (stored in way 4) -> no refill_req_valid; lru_we in cycle 2 with onehot 8'h10 and lru_hit=1; resp_hit=1, resp_way=4 in cycle 3.
- Backpressure: refill_req_ready held low for 5 cycles -> refill_req_valid, tag and way stable throughout. resp_ready held low for 3 cycles -> resp stable and req_ready=0.
- flush and req_valid together in IDLE -> all valid bits clear, request not accepted. A subsequent req for a previously present tag -> miss into way 0.
- rst=0 asserted in REFILL_WAIT -> next cycle IDLE with req_ready=1 and all other outputs 0. A later refill_done pulse -> no lru_we and no response.

Source files
------------

// File: rtl/lru_ctrl_pkg.sv
// Shared types and constants for the 8-way set replacement controller.
// Holds the controller state encoding, way/rank constants and a one-hot
// to index helper used by both the hit detector and the victim selector.
package lru_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOOKUP      = 3'd1,
    S_REFILL_REQ  = 3'd2,
    S_REFILL_WAIT = 3'd3,
    S_UPDATE      = 3'd4,
    S_RESP        = 3'd5
  } state_e;

  localparam int              WAYS     = 8;
  localparam int              RANK_W   = 3;
  localparam logic [RANK_W-1:0] RANK_LRU = 3'b000;
  localparam logic [RANK_W-1:0] RANK_MRU = 3'b111;

  // Index of the set bit of a one-hot vector; zero when no bit is set.
  function automatic logic [RANK_W-1:0] onehot2idx(input logic [WAYS-1:0] oh);
    logic [RANK_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (oh[i]) idx = idx | RANK_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lru_victim_sel.sv
// Victim way selection for a miss (purely combinational, zero latency).
// Ports: valid_i (per-way valid), lru_rank_i (3 bits per way) in;
//        victim_idx_o (way to fill), victim_invalid_o (victim is an empty way) out.
module lru_victim_sel
  import lru_ctrl_pkg::*;
(
  input  logic [WAYS-1:0]        valid_i,
  input  logic [WAYS*RANK_W-1:0] lru_rank_i,
  output logic [RANK_W-1:0]      victim_idx_o,
  output logic                   victim_invalid_o
);

  logic [WAYS-1:0]   inv;
  logic [WAYS-1:0]   inv_low;
  logic [RANK_W-1:0] rank_idx;

  assign inv     = ~valid_i;
  // Isolate the lowest set bit: lowest-index empty way wins.
  assign inv_low = inv & (~inv + WAYS'(1));

  // Scan downward so the lowest index holding rank 0 wins; if the ranks are
  // corrupt and none is 0, way 0 is the fallback.
  always_comb begin
    rank_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (lru_rank_i[i*RANK_W +: RANK_W] == RANK_LRU) rank_idx = RANK_W'(i);
    end
  end

  assign victim_invalid_o = |inv;
  assign victim_idx_o     = victim_invalid_o ? onehot2idx(inv_low) : rank_idx;

endmodule

// File: rtl/lru_replace_ctrl.sv
// Lookup / refill / LRU-update sequencer for one 8-way cache set; owns tags and valids.
// Ports: req_* lookup in, resp_* hit/way out, refill_* next-level handshake,
//        lru_rank from the rank block, lru_we/lru_way_onehot/lru_hit update to it.
module lru_replace_ctrl
  import lru_ctrl_pkg::*;
#(
  parameter int TAG_W = 20,
  parameter int WAYS  = lru_ctrl_pkg::WAYS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [TAG_W-1:0]        req_tag,
  input  logic                    flush,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_hit,
  output logic [2:0]              resp_way,
  output logic                    refill_req_valid,
  input  logic                    refill_req_ready,
  output logic [TAG_W-1:0]        refill_req_tag,
  output logic [2:0]              refill_req_way,
  input  logic                    refill_done,
  input  logic [3*WAYS-1:0]       lru_rank,
  output logic [WAYS-1:0]         lru_way_onehot,
  output logic                    lru_we,
  output logic                    lru_hit
);

  state_e            state_q;
  logic [WAYS-1:0]   valid_q;
  logic [TAG_W-1:0]  tags_q [WAYS];
  logic [TAG_W-1:0]  tag_q;       // tag of the request in flight
  logic [2:0]        way_q;       // hit way or victim way
  logic              hit_q;
  logic              fill_inv_q;  // victim was an empty way -> promote, else rotate

  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_hit_q;
  logic [2:0]        resp_way_q;
  logic              refill_req_valid_q;
  logic [TAG_W-1:0]  refill_req_tag_q;
  logic [2:0]        refill_req_way_q;
  logic [WAYS-1:0]   lru_way_onehot_q;
  logic              lru_we_q;
  logic              lru_hit_q;

  logic [WAYS-1:0]   hit_vec;
  logic [WAYS-1:0]   hit_low;
  logic              hit_any;
  logic [2:0]        hit_idx;
  logic [2:0]        victim_idx;
  logic              victim_invalid;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < WAYS; i++) begin
      hit_vec[i] = valid_q[i] && (tags_q[i] == tag_q);
    end
  end

  // Duplicate tags are possible only through misuse; lowest index wins.
  assign hit_low = hit_vec & (~hit_vec + WAYS'(1));
  assign hit_any = |hit_vec;
  assign hit_idx = onehot2idx(hit_low);

  lru_victim_sel u_victim_sel (
    .valid_i          (valid_q),
    .lru_rank_i       (lru_rank),
    .victim_idx_o     (victim_idx),
    .victim_invalid_o (victim_invalid)
  );

  // Every output is a register loaded on the transition into the state that
  // owns it, so nothing depends combinationally on the request inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q            <= S_IDLE;
      valid_q            <= '0;
      tag_q              <= '0;
      way_q              <= '0;
      hit_q              <= 1'b0;
      fill_inv_q         <= 1'b0;
      req_ready_q        <= 1'b1;
      resp_valid_q       <= 1'b0;
      resp_hit_q         <= 1'b0;
      resp_way_q         <= '0;
      refill_req_valid_q <= 1'b0;
      refill_req_tag_q   <= '0;
      refill_req_way_q   <= '0;
      lru_way_onehot_q   <= '0;
      lru_we_q           <= 1'b0;
      lru_hit_q          <= 1'b0;
    end else begin
      // LRU write is a single-cycle pulse; cleared unless re-armed below.
      lru_we_q         <= 1'b0;
      lru_way_onehot_q <= '0;
      lru_hit_q        <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (req_valid) begin
            tag_q       <= req_tag;
            req_ready_q <= 1'b0;
            state_q     <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (hit_any) begin
            way_q            <= hit_idx;
            hit_q            <= 1'b1;
            lru_we_q         <= 1'b1;
            lru_way_onehot_q <= hit_low;
            lru_hit_q        <= 1'b1;
            state_q          <= S_UPDATE;
          end else begin
            way_q              <= victim_idx;
            hit_q              <= 1'b0;
            fill_inv_q         <= victim_invalid;
            refill_req_valid_q <= 1'b1;
            refill_req_tag_q   <= tag_q;
            refill_req_way_q   <= victim_idx;
            state_q            <= S_REFILL_REQ;
          end
        end

        // refill_done seen here is a protocol error and is dropped.
        S_REFILL_REQ: begin
          if (refill_req_ready) begin
            refill_req_valid_q <= 1'b0;
            state_q            <= S_REFILL_WAIT;
          end
        end

        S_REFILL_WAIT: begin
          if (refill_done) begin
            tags_q[way_q]    <= tag_q;
            valid_q[way_q]   <= 1'b1;
            lru_we_q         <= 1'b1;
            lru_way_onehot_q <= WAYS'(1) << way_q;
            // Filling the rank-0 way: a rotate already makes it MRU.
            lru_hit_q        <= fill_inv_q;
            state_q          <= S_UPDATE;
          end
        end

        S_UPDATE: begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= hit_q;
          resp_way_q   <= way_q;
          state_q      <= S_RESP;
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_hit         = resp_hit_q;
  assign resp_way         = resp_way_q;
  assign refill_req_valid = refill_req_valid_q;
  assign refill_req_tag   = refill_req_tag_q;
  assign refill_req_way   = refill_req_way_q;
  assign lru_way_onehot   = lru_way_onehot_q;
  assign lru_we           = lru_we_q;
  assign lru_hit          = lru_hit_q;

endmodule
